// File: rtl/da_sched_pkg.sv
// Shared types and constants for the DA playback scheduler and its per-channel output stage.
package da_sched_pkg;

  localparam int         COUNT_W  = 13;
  localparam logic [9:0] MIDSCALE = 10'd512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2,
    STALL   = 2'd3
  } state_e;

endpackage

// File: rtl/da_chan_out.sv
// Per-channel DA output stage: read-valid delay, output register/midscale mux and underrun counter.
// The counter exists only when DA_SCHED_STAT_EN is defined; otherwise urun_cnt is tied to zero.
module da_chan_out
  import da_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rd_en,
  input  logic        urun,
  input  logic [7:0]  fifo_dout,
  output logic [9:0]  da_data,
  output logic [15:0] urun_cnt
);

  logic       vld_q;
  logic [9:0] da_q;
  logic [9:0] da_d;

  // A byte still in flight when the channel is disabled is dropped, keeping the output at midscale.
  always_comb begin
    da_d = MIDSCALE;
    if (vld_q && en) da_d = {fifo_dout, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      da_q  <= MIDSCALE;
    end else begin
      vld_q <= rd_en;
      da_q  <= da_d;
    end
  end

  assign da_data = da_q;

`ifdef DA_SCHED_STAT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (urun && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

  assign urun_cnt = cnt_q;
`else
  logic unused_urun;
  assign unused_urun = urun;
  assign urun_cnt    = 16'd0;
`endif

endmodule

// File: rtl/da_play_sched.sv
// Playback scheduler for DA channels A/B: prefill gate, phase-aligned start, joint underrun stall.
// Optional underrun statistics are enabled with the DA_SCHED_STAT_EN macro.
module da_play_sched
  import da_sched_pkg::*;
#(
  parameter logic [COUNT_W-1:0] START_LEVEL  = 13'd2048,
  parameter logic [COUNT_W-1:0] RESUME_LEVEL = 13'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         ch_en,
  input  logic [COUNT_W-1:0] rd_count_a,
  input  logic [COUNT_W-1:0] rd_count_b,
  input  logic               empty_a,
  input  logic               empty_b,
  input  logic [7:0]         fifo_dout_a,
  input  logic [7:0]         fifo_dout_b,
  output logic               rd_en_a,
  output logic               rd_en_b,
  output logic [9:0]         da_data_a,
  output logic [9:0]         da_data_b,
  output logic               playing,
  output logic [1:0]         underrun,
  output logic [15:0]        urun_cnt_a,
  output logic [15:0]        urun_cnt_b,
  output logic [1:0]         dbg_state
);

  logic [1:0] ch_en_q;
  state_e     state_q;
  state_e     state_d;
  logic       change;
  logic       start_ok;
  logic       resume_ok;
  logic [1:0] empty_v;
  logic [1:0] starved;

  assign change  = (ch_en != ch_en_q);
  assign empty_v = {empty_b, empty_a};
  assign starved = ch_en_q & empty_v;

  // A disabled channel never blocks a threshold transition.
  assign start_ok  = (~ch_en_q[0] | (rd_count_a >= START_LEVEL)) &
                     (~ch_en_q[1] | (rd_count_b >= START_LEVEL));
  assign resume_ok = (~ch_en_q[0] | (rd_count_a >= RESUME_LEVEL)) &
                     (~ch_en_q[1] | (rd_count_b >= RESUME_LEVEL));

  // An enable change restarts alignment and overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (change) begin
      state_d = (ch_en == 2'b00) ? IDLE : PREFILL;
    end else begin
      case (state_q)
        IDLE:    if (ch_en_q != 2'b00) state_d = PREFILL;
        PREFILL: if (start_ok)         state_d = PLAY;
        PLAY:    if (|starved)         state_d = STALL;
        STALL:   if (resume_ok)        state_d = PLAY;
        default:                       state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_en_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ch_en_q <= ch_en;
    end
  end

  // Reads decode from registered state, so both channels start on the same edge.
  assign rd_en_a   = (state_q == PLAY) & ch_en_q[0] & ~empty_a;
  assign rd_en_b   = (state_q == PLAY) & ch_en_q[1] & ~empty_b;
  assign underrun  = ((state_q == PLAY) && !change) ? starved : 2'b00;
  assign playing   = (state_q == PLAY);
  assign dbg_state = state_q;

  da_chan_out u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .en        (ch_en_q[0]),
    .rd_en     (rd_en_a),
    .urun      (underrun[0]),
    .fifo_dout (fifo_dout_a),
    .da_data   (da_data_a),
    .urun_cnt  (urun_cnt_a)
  );

  da_chan_out u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .en        (ch_en_q[1]),
    .rd_en     (rd_en_b),
    .urun      (underrun[1]),
    .fifo_dout (fifo_dout_b),
    .da_data   (da_data_b),
    .urun_cnt  (urun_cnt_b)
  );

endmodule
